// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem request/accept handshake, one-entry
// holding buffer for downstream stalls, halt detection and redirect handling.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  output logic [15:0] q_instr,
  output logic [15:0] q_PC_incr,
  output logic        q_valid,
  output logic        fetch_halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] hbuf_instr_q, hbuf_instr_d;
  logic [15:0] hbuf_pci_q, hbuf_pci_d;
  logic [15:0] q_instr_q, q_instr_d;
  logic [15:0] q_pci_q, q_pci_d;
  logic        q_valid_q, q_valid_d;

  logic [15:0] pc_incr;
  logic        rdata_is_halt;
  logic        hbuf_is_halt;

  assign pc_incr       = pc_q + 16'd2;
  assign rdata_is_halt = (imem_rdata[15:11] == 5'b00000);
  assign hbuf_is_halt  = (hbuf_instr_q[15:11] == 5'b00000);

  // The address comes straight from the PC register so a redirect never
  // creates a combinational path into the instruction memory.
  assign imem_addr    = pc_q;
  assign imem_req     = (state_q == FETCH);
  assign fetch_halted = (state_q == HALTED);
  assign q_instr      = q_instr_q;
  assign q_PC_incr    = q_pci_q;
  assign q_valid      = q_valid_q;

  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    hbuf_instr_d = hbuf_instr_q;
    hbuf_pci_d   = hbuf_pci_q;
    q_instr_d    = q_instr_q;
    q_pci_d      = q_pci_q;
    q_valid_d    = q_valid_q;

    if (redirect) begin
      state_d      = FETCH;
      pc_d         = redirect_pc;
      hbuf_instr_d = 16'h0000;
      hbuf_pci_d   = 16'h0000;
      q_instr_d    = NOP_INSTR;
      q_pci_d      = 16'h0000;
      q_valid_d    = 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc_incr;
            if (en) begin
              q_instr_d = imem_rdata;
              q_pci_d   = pc_incr;
              q_valid_d = 1'b1;
              state_d   = rdata_is_halt ? HALTED : FETCH;
            end else begin
              hbuf_instr_d = imem_rdata;
              hbuf_pci_d   = pc_incr;
              state_d      = HOLD;
            end
          end else if (en) begin
            q_instr_d = NOP_INSTR;
            q_pci_d   = 16'h0000;
            q_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (en) begin
            q_instr_d = hbuf_instr_q;
            q_pci_d   = hbuf_pci_q;
            q_valid_d = 1'b1;
            state_d   = hbuf_is_halt ? HALTED : FETCH;
          end
        end
        HALTED: begin
          if (en) begin
            q_instr_d = NOP_INSTR;
            q_pci_d   = 16'h0000;
            q_valid_d = 1'b0;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= 16'h0000;
      hbuf_instr_q <= 16'h0000;
      hbuf_pci_q   <= 16'h0000;
      q_instr_q    <= NOP_INSTR;
      q_pci_q      <= 16'h0000;
      q_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hbuf_instr_q <= hbuf_instr_d;
      hbuf_pci_q   <= hbuf_pci_d;
      q_instr_q    <= q_instr_d;
      q_pci_q      <= q_pci_d;
      q_valid_q    <= q_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step drives one clock of stimulus, pushes the
// expected IF/ID contents to a scoreboard and pops/compares them after the edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] q_instr;
  logic [15:0] q_PC_incr;
  logic        q_valid;
  logic        fetch_halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pci;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb[$];

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .q_instr     (q_instr),
    .q_PC_incr   (q_PC_incr),
    .q_valid     (q_valid),
    .fetch_halted(fetch_halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check request/address first, drive inputs, push expectation,
  // clock, then pop the expectation and compare the registered outputs.
  task automatic step(input logic r, input logic e, input logic rdy, input logic [15:0] rd,
                      input logic rdir, input logic [15:0] rpc,
                      input logic [15:0] exp_addr, input logic exp_req,
                      input logic [15:0] ei, input logic [15:0] ep, input logic ev,
                      input logic eh);
    exp_t x;
    check("imem_addr", imem_addr, exp_addr);
    check("imem_req", {15'd0, imem_req}, {15'd0, exp_req});
    rst = r; en = e; imem_ready = rdy; imem_rdata = rd;
    redirect = rdir; redirect_pc = rpc;
    sb.push_back('{instr: ei, pci: ep, valid: ev, halted: eh});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("q_instr", q_instr, x.instr);
    check("q_PC_incr", q_PC_incr, x.pci);
    check("q_valid", {15'd0, q_valid}, {15'd0, x.valid});
    check("fetch_halted", {15'd0, fetch_halted}, {15'd0, x.halted});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_rdata = 16'h0000; imem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_q_instr", q_instr, 16'h0800);
    check("rst_q_PC_incr", q_PC_incr, 16'h0000);
    check("rst_q_valid", {15'd0, q_valid}, 16'd0);
    check("rst_halted", {15'd0, fetch_halted}, 16'd0);

    // Straight-line fetch
    //   rst en rdy rdata    rdir rpc      addr     req  instr    pci      v    h
    step(0, 1, 1, 16'h4001, 0, 16'h0000, 16'h0000, 1, 16'h4001, 16'h0002, 1, 0);
    step(0, 1, 1, 16'h4102, 0, 16'h0000, 16'h0002, 1, 16'h4102, 16'h0004, 1, 0);

    // Memory wait at 0010
    step(0, 1, 0, 16'h4999, 1, 16'h0010, 16'h0004, 1, 16'h0800, 16'h0000, 0, 0);
    step(0, 1, 0, 16'h4999, 0, 16'h0000, 16'h0010, 1, 16'h0800, 16'h0000, 0, 0);
    step(0, 1, 0, 16'h4999, 0, 16'h0000, 16'h0010, 1, 16'h0800, 16'h0000, 0, 0);
    step(0, 1, 0, 16'h4999, 0, 16'h0000, 16'h0010, 1, 16'h0800, 16'h0000, 0, 0);
    step(0, 1, 1, 16'h4304, 0, 16'h0000, 16'h0010, 1, 16'h4304, 16'h0012, 1, 0);

    // Stall into HOLD at 0020 with a valid instruction already in IF/ID
    step(0, 1, 0, 16'h4999, 1, 16'h001E, 16'h0012, 1, 16'h0800, 16'h0000, 0, 0);
    step(0, 1, 1, 16'h4101, 0, 16'h0000, 16'h001E, 1, 16'h4101, 16'h0020, 1, 0);
    step(0, 0, 1, 16'h4203, 0, 16'h0000, 16'h0020, 1, 16'h4101, 16'h0020, 1, 0);
    step(0, 0, 1, 16'h4444, 0, 16'h0000, 16'h0022, 0, 16'h4101, 16'h0020, 1, 0);
    step(0, 0, 1, 16'h4444, 0, 16'h0000, 16'h0022, 0, 16'h4101, 16'h0020, 1, 0);
    step(0, 1, 1, 16'h4444, 0, 16'h0000, 16'h0022, 0, 16'h4203, 16'h0022, 1, 0);

    // Redirect beats a same-cycle accept with en=0
    step(0, 0, 1, 16'h4555, 1, 16'h0100, 16'h0022, 1, 16'h0800, 16'h0000, 0, 0);
    step(0, 1, 0, 16'h4555, 0, 16'h0000, 16'h0100, 1, 16'h0800, 16'h0000, 0, 0);

    // Halt fetched directly, then leave HALTED by redirect
    step(0, 1, 0, 16'h4999, 1, 16'h0030, 16'h0100, 1, 16'h0800, 16'h0000, 0, 0);
    step(0, 1, 1, 16'h0000, 0, 16'h0000, 16'h0030, 1, 16'h0000, 16'h0032, 1, 1);
    step(0, 1, 1, 16'h4666, 0, 16'h0000, 16'h0032, 0, 16'h0800, 16'h0000, 0, 1);
    step(0, 0, 1, 16'h4666, 1, 16'h0040, 16'h0032, 0, 16'h0800, 16'h0000, 0, 0);
    step(0, 1, 0, 16'h4999, 0, 16'h0000, 16'h0040, 1, 16'h0800, 16'h0000, 0, 0);

    // Halt accepted under stall, delivered through HOLD
    step(0, 1, 0, 16'h4999, 1, 16'h0050, 16'h0040, 1, 16'h0800, 16'h0000, 0, 0);
    step(0, 0, 1, 16'h0123, 0, 16'h0000, 16'h0050, 1, 16'h0800, 16'h0000, 0, 0);
    step(0, 1, 1, 16'h4999, 0, 16'h0000, 16'h0052, 0, 16'h0123, 16'h0052, 1, 1);

    // PC wrap at FFFE
    step(0, 1, 0, 16'h4999, 1, 16'hFFFE, 16'h0052, 0, 16'h0800, 16'h0000, 0, 0);
    step(0, 1, 1, 16'h4001, 0, 16'h0000, 16'hFFFE, 1, 16'h4001, 16'h0000, 1, 0);
    step(0, 1, 0, 16'h4999, 0, 16'h0000, 16'h0000, 1, 16'h0800, 16'h0000, 0, 0);

    // Reset while in HOLD, with a competing redirect
    step(0, 1, 1, 16'h4002, 0, 16'h0000, 16'h0000, 1, 16'h4002, 16'h0002, 1, 0);
    step(0, 0, 1, 16'h4777, 0, 16'h0000, 16'h0002, 1, 16'h4002, 16'h0002, 1, 0);
    step(1, 1, 1, 16'h4999, 1, 16'h1234, 16'h0004, 0, 16'h0800, 16'h0000, 0, 0);
    step(0, 1, 1, 16'h4888, 0, 16'h0000, 16'h0000, 1, 16'h4888, 16'h0002, 1, 0);
    check("final_addr", imem_addr, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
